// File: rtl/fft_res_comb_pingpong.sv
// fft_res_comb_pingpong
// Combines delayed FFT core samples with a correction term. Results are written
// into a two-bank ping-pong buffer, one frame per bank, and each completed
// frame is streamed out with valid/ready flow control.
// Optional macro FFT_COMB_SAT_EN: when defined, the combined sum saturates to
// the DATA_WIDTH signed range. When undefined, the sum wraps (keeps the low
// DATA_WIDTH bits).
module fft_res_comb_pingpong #(
  parameter int DATA_WIDTH  = 16,
  parameter int LOG2_LEN    = 15,
  parameter int ALIGN_DELAY = 5
) (
  input  logic                  clk_fft,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  input  logic [DATA_WIDTH+1:0] corr_real,
  input  logic [DATA_WIDTH+1:0] corr_imag,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [1:0]            bank_full,
  output logic                  frame_drop
);

  localparam int SUM_W = DATA_WIDTH + 2;
  localparam int LEN   = 1 << LOG2_LEN;
  localparam logic [LOG2_LEN-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} rd_state_t;

  // Reduce a full-precision sum to the output width.
  function automatic logic [DATA_WIDTH-1:0] reduce(input logic [SUM_W-1:0] sum);
`ifdef FFT_COMB_SAT_EN
    logic [2:0] top;
    top = sum[SUM_W-1:DATA_WIDTH-1];
    if (top == 3'b000 || top == 3'b111) return sum[DATA_WIDTH-1:0];
    else if (top[2])                     return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                                 return {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    return DATA_WIDTH'(sum);
`endif
  endfunction

  // ---------------------------------------------------------------- stage D
  logic                  dly_valid [ALIGN_DELAY];
  logic                  dly_sop   [ALIGN_DELAY];
  logic [DATA_WIDTH-1:0] dly_real  [ALIGN_DELAY];
  logic [DATA_WIDTH-1:0] dly_imag  [ALIGN_DELAY];

  // Alignment delay line for the core sample; the last entry is stage D.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the line.
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      for (int i = 0; i < ALIGN_DELAY; i++) begin
        dly_valid[i] <= 1'b0;
        dly_sop[i]   <= 1'b0;
        dly_real[i]  <= '0;
        dly_imag[i]  <= '0;
      end
    end else begin
      dly_valid[0] <= in_valid;
      dly_sop[0]   <= in_sop;
      dly_real[0]  <= in_real;
      dly_imag[0]  <= in_imag;
      for (int i = 1; i < ALIGN_DELAY; i++) begin
        dly_valid[i] <= dly_valid[i-1];
        dly_sop[i]   <= dly_sop[i-1];
        dly_real[i]  <= dly_real[i-1];
        dly_imag[i]  <= dly_imag[i-1];
      end
    end
  end

  logic [DATA_WIDTH-1:0] d_real, d_imag;
  logic [SUM_W-1:0]      sum_real, sum_imag;

  assign d_real   = dly_real[ALIGN_DELAY-1];
  assign d_imag   = dly_imag[ALIGN_DELAY-1];
  assign sum_real = {{2{d_real[DATA_WIDTH-1]}}, d_real} + corr_real;
  assign sum_imag = {{2{d_imag[DATA_WIDTH-1]}}, d_imag} + corr_imag;

  // ---------------------------------------------------------------- stage S
  logic             s_valid, s_sop;
  logic [SUM_W-1:0] s_real, s_imag;

  // Full-precision sum register.
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_sop   <= 1'b0;
      s_real  <= '0;
      s_imag  <= '0;
    end else begin
      s_valid <= dly_valid[ALIGN_DELAY-1];
      s_sop   <= dly_sop[ALIGN_DELAY-1];
      s_real  <= sum_real;
      s_imag  <= sum_imag;
    end
  end

  // ---------------------------------------------------------------- writer
  logic [LOG2_LEN-1:0] wr_addr, wr_idx;
  logic                wb, frame_open, frame_drop_q;
  logic                do_write, do_drop, wr_last;
  logic                rb, rd_en, rd_done;
  logic [LOG2_LEN-1:0] rd_ptr, rd_idx, out_idx;

  // Write decision: a sop (re)starts a frame unless its bank is still full.
  always_comb begin
    wr_idx   = s_sop ? '0 : wr_addr;
    do_write = s_valid && (s_sop ? !bank_full[wb] : frame_open);
    do_drop  = s_valid && s_sop && bank_full[wb];
    wr_last  = (wr_idx == LAST_ADDR);
  end

  // Write pointer, bank select and per-bank full flags.
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      wr_addr      <= '0;
      wb           <= 1'b0;
      frame_open   <= 1'b0;
      bank_full    <= 2'b00;
      frame_drop_q <= 1'b0;
    end else begin
      frame_drop_q <= do_drop;
      if (do_drop) frame_open <= 1'b0;
      if (do_write) begin
        if (wr_last) begin
          bank_full[wb] <= 1'b1;
          wb            <= ~wb;
          frame_open    <= 1'b0;
          wr_addr       <= '0;
        end else begin
          wr_addr    <= wr_idx + 1'b1;
          frame_open <= 1'b1;
        end
      end
      // The reader only clears the bank it streams, which is never the bank
      // being written, so the two updates touch different bits.
      if (rd_done) bank_full[rb] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- memory
  logic [DATA_WIDTH-1:0] mem_real [2*LEN];
  logic [DATA_WIDTH-1:0] mem_imag [2*LEN];
  logic [DATA_WIDTH-1:0] rd_real, rd_imag;

  // Dual-port buffer: bank bit on top of the frame address.
  // NOTE: no reset on the arrays or read register -- contents are don't-care
  // after reset and a reset would prevent RAM inference.
  always_ff @(posedge clk_fft) begin
    if (do_write) begin
      mem_real[{wb, wr_idx}] <= reduce(s_real);
      mem_imag[{wb, wr_idx}] <= reduce(s_imag);
    end
    if (rd_en) begin
      rd_real <= mem_real[{rb, rd_idx}];
      rd_imag <= mem_imag[{rb, rd_idx}];
    end
  end

  // ---------------------------------------------------------------- reader
  rd_state_t state, state_next;
  logic      accept;

  assign out_valid = (state == ST_STREAM) && !reset;
  assign accept    = out_valid && out_ready;

  // Read FSM state register.
  always_ff @(posedge clk_fft) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Read FSM next state and read strobes.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_idx     = rd_ptr;
    rd_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bank_full[rb]) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        rd_en      = 1'b1;
        rd_idx     = '0;
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept) begin
          if (out_idx == LAST_ADDR) begin
            rd_done    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read pointer, address of the presented sample, and read bank select.
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      rd_ptr  <= '0;
      out_idx <= '0;
      rb      <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr  <= rd_idx + 1'b1;
        out_idx <= rd_idx;
      end
      if (rd_done) rb <= ~rb;
    end
  end

  assign out_real   = out_valid ? rd_real : '0;
  assign out_imag   = out_valid ? rd_imag : '0;
  assign out_sop    = out_valid && (out_idx == '0);
  assign out_eop    = out_valid && (out_idx == LAST_ADDR);
  assign frame_drop = frame_drop_q && !reset;

endmodule
